// File: rtl/mem_port_arbiter.sv
// Two-requester (instruction fetch / data) arbiter for a single fixed-latency memory port.
// Round-robin on ties, no preemption, all outputs registered.
module mem_port_arbiter #(
    parameter int unsigned MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [63:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [63:0] d_addr,
    input  logic [63:0] d_wdata,
    output logic [63:0] d_rdata,
    output logic        d_ack,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic        mem_wr,
    input  logic [63:0] mem_rdata,
    output logic [1:0]  grant,
    output logic [1:0]  state_out,
    output logic [15:0] wait_cnt
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StResp   = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        last_was_d_q, last_was_d_d;
    logic        we_q, we_d;
    logic        pick_d;
    logic [1:0]  grant_d;
    logic [63:0] mem_addr_d, mem_wdata_d;
    logic        mem_wr_d;
    logic [31:0] i_rdata_d;
    logic [63:0] d_rdata_d;
    logic        i_ack_d, d_ack_d;
    logic [15:0] wait_cnt_d;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_was_d_d = last_was_d_q;
        we_d         = we_q;
        pick_d       = 1'b0;
        grant_d      = grant;
        mem_addr_d   = mem_addr;
        mem_wdata_d  = mem_wdata;
        mem_wr_d     = 1'b0;
        i_rdata_d    = i_rdata;
        d_rdata_d    = d_rdata;
        i_ack_d      = 1'b0;
        d_ack_d      = 1'b0;
        wait_cnt_d   = wait_cnt;

        unique case (state_q)
            StIdle: begin
                grant_d = 2'b00;
                if (i_req || d_req) begin
                    // D wins when alone, or on a tie when I was served last.
                    pick_d       = d_req && (!i_req || !last_was_d_q);
                    state_d      = StAccess;
                    cnt_d        = 3'd0;
                    last_was_d_d = pick_d;
                    we_d         = pick_d && d_we;
                    grant_d      = pick_d ? 2'b10 : 2'b01;
                    mem_addr_d   = pick_d ? d_addr : i_addr;
                    mem_wdata_d  = pick_d ? d_wdata : 64'h0;
                    mem_wr_d     = pick_d && d_we;
                end
            end
            StAccess: begin
                if (cnt_q == 3'(MEM_LAT - 1)) begin
                    state_d     = StResp;
                    mem_addr_d  = 64'h0;
                    mem_wdata_d = 64'h0;
                    i_ack_d     = grant[0];
                    d_ack_d     = grant[1];
                    if (grant[0]) begin
                        i_rdata_d = mem_addr[2] ? mem_rdata[63:32] : mem_rdata[31:0];
                    end
                    if (grant[1] && !we_q) begin
                        d_rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
                grant_d = 2'b00;
            end
            default: begin
                state_d = StIdle;
                grant_d = 2'b00;
            end
        endcase

        if (state_q != StIdle && ((grant[0] && d_req) || (grant[1] && i_req))
            && wait_cnt != 16'hFFFF) begin
            wait_cnt_d = wait_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= StIdle;
            cnt_q        <= 3'd0;
            last_was_d_q <= 1'b0;
            we_q         <= 1'b0;
            grant        <= 2'b00;
            state_out    <= 2'd0;
            mem_addr     <= 64'h0;
            mem_wdata    <= 64'h0;
            mem_wr       <= 1'b0;
            i_rdata      <= 32'h0;
            d_rdata      <= 64'h0;
            i_ack        <= 1'b0;
            d_ack        <= 1'b0;
            wait_cnt     <= 16'h0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_was_d_q <= last_was_d_d;
            we_q         <= we_d;
            grant        <= grant_d;
            state_out    <= state_d;
            mem_addr     <= mem_addr_d;
            mem_wdata    <= mem_wdata_d;
            mem_wr       <= mem_wr_d;
            i_rdata      <= i_rdata_d;
            d_rdata      <= d_rdata_d;
            i_ack        <= i_ack_d;
            d_ack        <= d_ack_d;
            wait_cnt     <= wait_cnt_d;
        end
    end

endmodule
